// File: rtl/signal_query_arbiter_if.sv
// Bundle between the per-stage trackers, the query arbiter and the shared
// signal_tracker_time_test buffer. The arbiter connects through the slave
// modport; whoever drives the requests and models the buffer uses master.
interface signal_query_arbiter_if #(
   parameter int NUM_REQ     = 4,
   parameter int QUERY_WIDTH = 32
);
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ*QUERY_WIDTH-1:0] query_value;
   logic [NUM_REQ-1:0]             resp_valid;
   logic [QUERY_WIDTH-1:0]         resp_time;
   logic                           resp_timeout;
   logic                           busy;
   logic [QUERY_WIDTH-1:0]         tb_value_in;
   logic                           tb_recalculate;
   logic                           tb_data_valid;
   logic [QUERY_WIDTH-1:0]         tb_time_out;

   modport master (
      output req, query_value, tb_data_valid, tb_time_out,
      input  resp_valid, resp_time, resp_timeout, busy, tb_value_in, tb_recalculate
   );

   modport slave (
      input  req, query_value, tb_data_valid, tb_time_out,
      output resp_valid, resp_time, resp_timeout, busy, tb_value_in, tb_recalculate
   );
endinterface

// File: rtl/signal_query_arbiter.sv
// Round-robin arbiter sharing one signal-tracker time-test query port between
// several tracker stages. One query is in flight at a time; the result (or -1
// after a timeout) is handed back only to the requester that was granted.
module signal_query_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int QUERY_WIDTH    = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                  clk,
   input logic                  rst,
   signal_query_arbiter_if.slave bus
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE,
      QUERY,
      RESPOND
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic [PW-1:0]          rr_ptr;
   logic [PW-1:0]          grant_idx;
   logic [PW-1:0]          grant_sel;
   logic                   grant_found;
   int                     cand;
   logic [CW-1:0]          wait_cnt;
   logic                   timeout_hit;
   logic [QUERY_WIDTH-1:0] query_reg;
   logic [QUERY_WIDTH-1:0] result_reg;
   logic                   timeout_flag;
   logic [NUM_REQ-1:0]     resp_vec;

   assign timeout_hit = (wait_cnt == WAIT_LAST);

   // Cyclic search for the first pending request at or after rr_ptr
   always_comb begin
      grant_found = 1'b0;
      grant_sel   = '0;
      cand        = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(rr_ptr) + k) % NUM_REQ;
         if (!grant_found && bus.req[cand]) begin
            grant_found = 1'b1;
            grant_sel   = PW'(cand);
         end
      end
   end

   // State register; reset abandons whatever query is in flight
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic; a result arriving on the timeout cycle still wins
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (grant_found) next_state = QUERY;
         QUERY:   if (bus.tb_data_valid || timeout_hit) next_state = RESPOND;
         RESPOND: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Grant latch, saturating wait counter, result capture and pointer advance
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr       <= '0;
         grant_idx    <= '0;
         wait_cnt     <= '0;
         query_reg    <= '0;
         result_reg   <= '0;
         timeout_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  grant_idx <= grant_sel;
                  query_reg <= bus.query_value[int'(grant_sel)*QUERY_WIDTH +: QUERY_WIDTH];
                  wait_cnt  <= '0;
               end
            end
            QUERY: begin
               if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
               if (bus.tb_data_valid) begin
                  result_reg   <= bus.tb_time_out;
                  timeout_flag <= 1'b0;
               end else if (timeout_hit) begin
                  result_reg   <= '1;
                  timeout_flag <= 1'b1;
               end
            end
            RESPOND: begin
               rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Pulse only the granted requester, and only if it is still waiting
   always_comb begin
      resp_vec = '0;
      if (state == RESPOND && bus.req[grant_idx]) resp_vec[grant_idx] = 1'b1;
   end

   assign bus.resp_valid     = resp_vec;
   assign bus.resp_time      = result_reg;
   assign bus.resp_timeout   = (state == RESPOND) && timeout_flag;
   assign bus.busy           = (state != IDLE);
   assign bus.tb_value_in    = query_reg;
   assign bus.tb_recalculate = (state == QUERY);
endmodule

// File: tb/tb_signal_query_arbiter.sv
// Testbench for signal_query_arbiter: plays the tracker stages and the shared
// buffer, predicts each grant and result from a round-robin reference model
// and checks the responses through a scoreboard queue.
module tb_signal_query_arbiter;
   localparam int NUM_REQ        = 4;
   localparam int QUERY_WIDTH    = 32;
   localparam int TIMEOUT_CYCLES = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   signal_query_arbiter_if #(.NUM_REQ(NUM_REQ), .QUERY_WIDTH(QUERY_WIDTH)) bus ();

   signal_query_arbiter #(
      .NUM_REQ(NUM_REQ),
      .QUERY_WIDTH(QUERY_WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int                     idx;
      logic [QUERY_WIDTH-1:0] rtime;
      logic                   rto;
   } exp_t;

   exp_t                   sb[$];
   exp_t                   mon_e;
   logic [NUM_REQ-1:0]     mon_onehot;
   int                     checks = 0;
   int                     failures = 0;

   logic [NUM_REQ-1:0]     req_drv;
   logic [NUM_REQ-1:0]     req_prev;
   logic [QUERY_WIDTH-1:0] qv[NUM_REQ];
   logic [QUERY_WIDTH-1:0] qv_prev[NUM_REQ];
   logic                   prev_rc;
   logic                   prev_respond;
   int                     rcnt;
   int                     plan_d;
   int                     exp_len;
   int                     cur_g;
   int                     model_ptr;
   int                     release_g;
   logic [QUERY_WIDTH-1:0] plan_time;
   logic [QUERY_WIDTH-1:0] cur_q;
   bit                     plan_drop;
   int                     dir_delay;
   logic [QUERY_WIDTH-1:0] dir_time;
   bit                     dir_drop;
   bit                     rand_traffic;

   // One comparison: counts it and reports a FAIL line on mismatch
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference round robin: first set request at or after ptr, wrapping
   function automatic int findGrant(input logic [NUM_REQ-1:0] r, input int ptr);
      for (int k = 0; k < NUM_REQ; k++)
         if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      return -1;
   endfunction

   // Drive requests/queries and remember what the DUT sees this cycle
   task automatic driveBus();
      logic [NUM_REQ*QUERY_WIDTH-1:0] packed_q;
      packed_q = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         packed_q[i*QUERY_WIDTH +: QUERY_WIDTH] = qv[i];
         qv_prev[i] = qv[i];
      end
      bus.req         = req_drv;
      bus.query_value = packed_q;
      req_prev        = req_drv;
   endtask

   // Decide how the buffer answers the query that was just granted
   task automatic choosePlan();
      int r;
      if (dir_delay >= 0) begin
         plan_d    = dir_delay;
         plan_time = dir_time;
         plan_drop = dir_drop;
      end else begin
         r = $urandom_range(0, 99);
         if (r < 75)      plan_d = $urandom_range(1, 4);
         else if (r < 85) plan_d = TIMEOUT_CYCLES + 1;
         else if (r < 90) plan_d = TIMEOUT_CYCLES;
         else             plan_d = $urandom_range(5, TIMEOUT_CYCLES - 1);
         plan_time = $urandom;
         plan_drop = ($urandom_range(0, 9) == 0);
      end
   endtask

   // One clock of requester + buffer behaviour, with grant prediction
   task automatic applyStimulus();
      logic                   rc;
      logic                   respond;
      logic                   dv;
      logic                   rel_now;
      int                     g;
      exp_t                   e;
      @(posedge clk);
      #1;
      rc      = bus.tb_recalculate;
      respond = prev_rc && !rc;
      rel_now = 1'b0;
      if (!prev_rc && !prev_respond && req_prev != '0)
         checkOutput("grant_issued", 64'(rc), 64'd1);
      checkOutput("busy", 64'(bus.busy), 64'(rc || respond));
      if (!prev_rc && rc) begin
         g = findGrant(req_prev, model_ptr);
         checkOutput("grant_has_req", 64'(g >= 0), 64'd1);
         if (g < 0) g = 0;
         cur_g     = g;
         cur_q     = qv_prev[g];
         model_ptr = (g + 1) % NUM_REQ;
         choosePlan();
         exp_len = (plan_d <= TIMEOUT_CYCLES) ? plan_d : TIMEOUT_CYCLES;
         e.idx   = g;
         e.rto   = (plan_d > TIMEOUT_CYCLES);
         e.rtime = e.rto ? {QUERY_WIDTH{1'b1}} : plan_time;
         if (!plan_drop) sb.push_back(e);
         rcnt = 0;
      end
      dv = 1'b0;
      if (rc) begin
         rcnt++;
         checkOutput("tb_value_in", 64'(bus.tb_value_in), 64'(cur_q));
         dv = (rcnt == plan_d);
         if (plan_drop && rcnt == 1) req_drv[cur_g] = 1'b0;
         if (rcnt == 2) qv[cur_g] = $urandom;
      end else if (rand_traffic) begin
         dv = ($urandom_range(0, 3) == 0);
      end
      bus.tb_data_valid = dv;
      bus.tb_time_out   = (rc && dv) ? plan_time : QUERY_WIDTH'($urandom);
      if (respond) begin
         checkOutput("query_cycles", 64'(rcnt), 64'(exp_len));
         release_g = cur_g;
      end else if (release_g >= 0) begin
         req_drv[release_g] = 1'b0;
         release_g = -1;
         rel_now   = 1'b1;
      end
      if (rand_traffic) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!(i == cur_g && (rc || respond || rel_now))) begin
               if (req_drv[i] && $urandom_range(0, 29) == 0) begin
                  req_drv[i] = 1'b0;
               end else if (!req_drv[i] && $urandom_range(0, 5) == 0) begin
                  req_drv[i] = 1'b1;
                  qv[i] = $urandom;
               end else if ($urandom_range(0, 4) == 0) begin
                  qv[i] = $urandom;
               end
            end
         end
      end
      prev_rc      = rc;
      prev_respond = respond;
      driveBus();
   endtask

   // Step until every request has been serviced or withdrawn
   task automatic runUntilIdle(input int bound, input string name);
      int n;
      n = 0;
      while (!(req_drv == '0 && !prev_rc && !prev_respond && release_g < 0) && n < bound) begin
         applyStimulus();
         n++;
      end
      checkOutput(name, 64'(n < bound), 64'd1);
   endtask

   // Monitor: every response pulse is matched against the next expectation
   always @(negedge clk) begin
      if (!rst && bus.resp_valid != '0) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_resp", 64'(bus.resp_valid), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            mon_onehot = '0;
            mon_onehot[mon_e.idx] = 1'b1;
            checkOutput("resp_valid", 64'(bus.resp_valid), 64'(mon_onehot));
            checkOutput("resp_time", 64'(bus.resp_time), 64'(mon_e.rtime));
            checkOutput("resp_timeout", 64'(bus.resp_timeout), 64'(mon_e.rto));
         end
      end
   end

   // Directed scenarios first, then randomized traffic, then drain and report
   initial begin
      int n;
      req_drv           = '0;
      for (int i = 0; i < NUM_REQ; i++) qv[i] = '0;
      bus.tb_data_valid = 1'b0;
      bus.tb_time_out   = '0;
      prev_rc           = 1'b0;
      prev_respond      = 1'b0;
      rcnt              = 0;
      plan_d            = 1;
      exp_len           = 1;
      cur_g             = 0;
      model_ptr         = 0;
      release_g         = -1;
      plan_time         = '0;
      cur_q             = '0;
      plan_drop         = 1'b0;
      dir_delay         = 2;
      dir_time          = '0;
      dir_drop          = 1'b0;
      rand_traffic      = 1'b0;
      driveBus();

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("rst_recalc", 64'(bus.tb_recalculate), 64'd0);
      checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      checkOutput("rst_resp_time", 64'(bus.resp_time), 64'd0);
      checkOutput("rst_resp_timeout", 64'(bus.resp_timeout), 64'd0);
      checkOutput("rst_value_in", 64'(bus.tb_value_in), 64'd0);
      rst = 1'b0;

      $display("[TB] single request on stage 2");
      dir_delay = 2; dir_time = 100; dir_drop = 1'b0;
      req_drv[2] = 1'b1; qv[2] = 5;
      runUntilIdle(50, "single_done");

      $display("[TB] buffer never answers");
      dir_delay = TIMEOUT_CYCLES + 1; dir_time = 55;
      req_drv[0] = 1'b1; qv[0] = $urandom;
      runUntilIdle(200, "timeout_done");

      $display("[TB] answer on the timeout cycle");
      dir_delay = TIMEOUT_CYCLES; dir_time = 7;
      req_drv[3] = 1'b1; qv[3] = $urandom;
      runUntilIdle(200, "edge_done");

      $display("[TB] requester withdraws while waiting");
      dir_delay = 5; dir_time = 33; dir_drop = 1'b1;
      req_drv[1] = 1'b1; qv[1] = $urandom;
      runUntilIdle(50, "drop_done");
      dir_drop = 1'b0; dir_delay = 1; dir_time = 44;
      req_drv = 4'b1011;
      for (int i = 0; i < NUM_REQ; i++) qv[i] = $urandom;
      runUntilIdle(100, "after_drop_done");

      $display("[TB] reset during a query");
      dir_delay = TIMEOUT_CYCLES + 1;
      req_drv[3] = 1'b1; qv[3] = $urandom;
      n = 0;
      while (!prev_rc && n < 20) begin applyStimulus(); n++; end
      checkOutput("reset_test_granted", 64'(prev_rc), 64'd1);
      repeat (3) applyStimulus();
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_recalc", 64'(bus.tb_recalculate), 64'd0);
      checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
      checkOutput("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
      rst = 1'b0;
      if (sb.size() > 0) void'(sb.pop_back());
      model_ptr    = 0;
      prev_rc      = 1'b0;
      prev_respond = 1'b0;
      release_g    = -1;
      req_drv      = '1;
      for (int i = 0; i < NUM_REQ; i++) qv[i] = $urandom;
      driveBus();
      dir_delay = 3; dir_time = 12;
      runUntilIdle(100, "post_reset_done");

      $display("[TB] randomized traffic");
      dir_delay    = -1;
      rand_traffic = 1'b1;
      repeat (1500) applyStimulus();
      rand_traffic = 1'b0;
      runUntilIdle(3000, "drain_done");
      repeat (3) applyStimulus();
      checkOutput("sb_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
